// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display scheduler: FSM encoding,
// digit geometry, default timing constants and small digit helpers.
package display_pkg;

    localparam int N_DIGITS        = 8;
    localparam int MAX_SRC         = 8;
    localparam int BCD_W           = 32;
    localparam int DEF_SCAN_DIV    = 150000;
    localparam int DEF_REFRESH_CYC = 1000000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Shift-add-3 correction applied to one BCD digit before each shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // Bit i set when digit i lies above the most significant nonzero digit.
    // Digit 0 is never marked, so a zero value still shows one "0".
    function automatic logic [N_DIGITS-1:0] lzb_mask(input logic [BCD_W-1:0] value);
        logic [N_DIGITS-1:0] mask;
        logic                seen;
        mask = '0;
        seen = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (value[4*i +: 4] != 4'd0) seen = 1'b1;
            mask[i] = ~seen;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative 32-bit binary to 8-digit BCD converter (shift-add-3), one bit per
// cycle; digits beyond the eighth are dropped, giving the value mod 10^8.
module bin2bcd_iter
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      bin_in,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    logic [31:0]      bin_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-2:0] bcd_adj;
    logic [4:0]       cnt_reg;
    logic             active_reg;

    // The top bit of the adjusted top digit is shifted out and discarded,
    // so only its low three bits are kept.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            if (gi < N_DIGITS - 1) begin : g_full
                assign bcd_adj[4*gi +: 4] = add3(bcd_reg[4*gi +: 4]);
            end else begin : g_top
                assign bcd_adj[4*gi +: 3] = 3'(add3(bcd_reg[4*gi +: 4]));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg    <= '0;
            bcd_reg    <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (abort) begin
            active_reg <= 1'b0;
        end else if (start) begin
            bin_reg    <= bin_in;
            bcd_reg    <= '0;
            cnt_reg    <= 5'd31;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            bcd_reg <= {bcd_adj, bin_reg[31]};
            bin_reg <= {bin_reg[30:0], 1'b0};
            if (cnt_reg == 5'd0) begin
                active_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 5'd1;
            end
        end
    end

    // Asserted during the final iteration; the result is stable next cycle.
    assign done    = active_reg && (cnt_reg == 5'd0);
    assign bcd_out = bcd_reg;

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 8-digit display between N_SRC pages, converts the selected
// value to hex or decimal and scans the digits. DISP_LZB_EN enables leading-zero blanking.
module display_scheduler
    import display_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int SCAN_DIV    = DEF_SCAN_DIV,
    parameter int REFRESH_CYC = DEF_REFRESH_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [32*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]    src_hex,
    input  logic                next,
    output logic [3:0]          dig,
    output logic [2:0]          pos,
    output logic                point,
    output logic                off,
    output logic [2:0]          page,
    output logic                busy
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int REF_W  = $clog2(REFRESH_CYC);

    logic [1:0]        state_reg, state_next;
    logic [2:0]        page_reg;
    logic              first_reg;
    logic [REF_W-1:0]  refresh_cnt_reg;
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [2:0]        pos_reg, pos_next;
    logic [BCD_W-1:0]  disp_reg, disp_next;
    logic              disp_valid_reg, valid_next;
    logic              off_reg, off_next;
    logic              busy_reg;
    logic [31:0]       sample_reg;
    logic              hex_reg;

    logic              refresh_tick, scan_tick, start_req;
    logic              conv_start, conv_done, commit;
    logic [BCD_W-1:0]  conv_bcd;

    // Source words padded to eight slots so a 3-bit page always indexes safely.
    logic [31:0]         src_word [MAX_SRC];
    logic [MAX_SRC-1:0]  hex_vec;
    logic [3:0]          disp_nib [N_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SRC; gi++) begin : g_src
            if (gi < N_SRC) begin : g_used
                assign src_word[gi] = src_data[32*gi +: 32];
                assign hex_vec[gi]  = src_hex[gi];
            end else begin : g_pad
                assign src_word[gi] = '0;
                assign hex_vec[gi]  = 1'b0;
            end
        end
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
            assign disp_nib[gi] = disp_reg[4*gi +: 4];
        end
    endgenerate

    assign refresh_tick = (refresh_cnt_reg == REF_W'(REFRESH_CYC - 1));
    assign scan_tick    = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
    assign start_req    = first_reg | next | refresh_tick;

    // A page change restarts from LOAD in every state, dropping any pending commit.
    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        commit     = 1'b0;
        if (next) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_req) state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    if (hex_vec[page_reg]) begin
                        state_next = ST_COMMIT;
                    end else begin
                        state_next = ST_CONV;
                        conv_start = 1'b1;
                    end
                end
                ST_CONV: begin
                    if (conv_done) state_next = ST_COMMIT;
                end
                default: begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // off is registered, so it is computed from the values the display and
    // scan position will hold after this edge.
`ifdef DISP_LZB_EN
    logic [N_DIGITS-1:0] blank_mask;
`endif
    always_comb begin
        disp_next  = disp_reg;
        valid_next = disp_valid_reg;
        if (commit) begin
            disp_next  = hex_reg ? sample_reg : conv_bcd;
            valid_next = 1'b1;
        end
        pos_next = scan_tick ? pos_reg + 3'd1 : pos_reg;
`ifdef DISP_LZB_EN
        blank_mask = lzb_mask(disp_next);
        off_next   = ~valid_next | blank_mask[pos_next];
`else
        off_next   = ~valid_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            page_reg        <= '0;
            first_reg       <= 1'b1;
            refresh_cnt_reg <= '0;
            scan_cnt_reg    <= '0;
            pos_reg         <= '0;
            disp_reg        <= '0;
            disp_valid_reg  <= 1'b0;
            off_reg         <= 1'b1;
            busy_reg        <= 1'b0;
            sample_reg      <= '0;
            hex_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            first_reg       <= 1'b0;
            refresh_cnt_reg <= refresh_tick ? '0 : refresh_cnt_reg + 1'b1;
            scan_cnt_reg    <= scan_tick ? '0 : scan_cnt_reg + 1'b1;
            pos_reg         <= pos_next;
            disp_reg        <= disp_next;
            disp_valid_reg  <= valid_next;
            off_reg         <= off_next;
            busy_reg        <= (state_next != ST_IDLE);
            if (next) begin
                page_reg <= (page_reg == 3'(N_SRC - 1)) ? 3'd0 : page_reg + 3'd1;
            end
            if (state_reg == ST_LOAD) begin
                sample_reg <= src_word[page_reg];
                hex_reg    <= hex_vec[page_reg];
            end
        end
    end

    bin2bcd_iter u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (conv_start),
        .abort   (next),
        .bin_in  (src_word[page_reg]),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    assign dig   = disp_nib[pos_reg];
    assign point = disp_valid_reg && (pos_reg == page_reg) && !off_reg;
    assign pos   = pos_reg;
    assign off   = off_reg;
    assign page  = page_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed plus randomized bench for display_scheduler; expected digits come
// from plain arithmetic on the source values, expected scan from a cycle count.
module tb_display_scheduler;

    localparam int N_SRC = 2;
    localparam int SD    = 3;
    localparam int RC    = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        next;
    logic [63:0] src_data;
    logic [1:0]  src_hex;
    logic [3:0]  dig;
    logic [2:0]  pos;
    logic        point;
    logic        off;
    logic [2:0]  page;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          page_m;
    logic [31:0] src_v [2];
    logic        src_h [2];
    logic [31:0] disp_m;
    logic [31:0] tv [5];
    logic        th [5];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    display_scheduler #(.N_SRC(N_SRC), .SCAN_DIV(SD), .REFRESH_CYC(RC)) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .src_hex(src_hex), .next(next),
        .dig(dig), .pos(pos), .point(point), .off(off), .page(page), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_disp(input logic [31:0] v, input logic h);
        logic [31:0]     r;
        longint unsigned q;
        if (h) return v;
        q = longint'(v) % 64'd100000000;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(q % 10);
            q = q / 10;
        end
        return r;
    endfunction

    function automatic int model_pos();
        return (cyc / SD) % 8;
    endfunction

    function automatic logic exp_off(input logic [31:0] d, input int p);
        logic lzb;
`ifdef DISP_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        return lzb && (p != 0) && ((d >> (4 * p)) == 32'd0);
    endfunction

    task automatic tick();
        @(negedge clk);
        check("pos", 32'(pos), 32'(model_pos()));
    endtask

    task automatic check_digit(input string tag, input logic [31:0] d);
        int         p;
        logic       o;
        logic [3:0] nib;
        p   = model_pos();
        o   = exp_off(d, p);
        nib = d[4*p +: 4];
        check({tag, "_dig"}, 32'(dig), 32'(nib));
        check({tag, "_off"}, 32'(off), 32'(o));
        check({tag, "_point"}, 32'(point), 32'((p == page_m) && !o));
        $display("cycle %0d %s: pos=%0d dig=%0h off=%0b point=%0b page=%0d", cyc, tag, pos, dig, off, point, page);
    endtask

    task automatic check_display(input string tag);
        repeat (8 * SD) begin
            tick();
            check_digit(tag, disp_m);
        end
    endtask

    task automatic drive_src();
        src_data = {src_v[1], src_v[0]};
        src_hex  = {src_h[1], src_h[0]};
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic pulse_next();
        next   = 1'b1;
        page_m = (page_m + 1) % N_SRC;
        tick();
        next   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dig"}, 32'(dig), 32'd0);
        check({tag, "_point"}, 32'(point), 32'd0);
        check({tag, "_off"}, 32'(off), 32'd1);
        check({tag, "_page"}, 32'(page), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old_d, new_d, v;
        logic        h;
        int          tgt, lat, ones, n;

        // Reset and boot-time conversion of page 0.
        rst = 1'b1; next = 1'b0; page_m = 0;
        src_v[0] = 32'd12345678; src_h[0] = 1'b0;
        src_v[1] = 32'hDEADBEEF; src_h[1] = 1'b1;
        drive_src();
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        disp_m = expect_disp(src_v[0], src_h[0]);
        for (int k = 1; k <= 35; k++) begin
            tick();
            check("boot_busy", 32'(busy), 32'(k <= 34));
            if (k <= 34) check("boot_off", 32'(off), 32'd1);
        end
        check_digit("boot_first", disp_m);
        check_display("boot");

        // Hex page: new digits exactly three cycles after the pulse.
        old_d = disp_m;
        new_d = expect_disp(src_v[1], src_h[1]);
        pulse_next();
        tick();
        check_digit("hex_old", old_d);
        tick();
        check_digit("hex_new", new_d);
        check("hex_page", 32'(page), 32'd1);
        disp_m = new_d;
        wait_idle(10);
        check_display("hex");

        // Abort: pulses at CONV iteration 10 and five cycles later.
        old_d = disp_m;
        src_v[0] = 32'd87654321; src_v[1] = 32'd13572468; src_h[1] = 1'b0;
        drive_src();
        new_d = expect_disp(src_v[0], 1'b0);
        next = 1'b1; page_m = 0;
        for (int k = 1; k <= 52; k++) begin
            tick();
            if (k < 52) check_digit("abort_hold", old_d);
            else        check_digit("abort_new", new_d);
            if (k == 51) check("abort_busy_commit", 32'(busy), 32'd1);
            if (k == 52) check("abort_busy_done", 32'(busy), 32'd0);
            next = (k == 12 || k == 17);
            if (next) page_m = (page_m + 1) % N_SRC;
        end
        check("abort_page", 32'(page), 32'd0);
        disp_m = new_d;
        check_display("abort");

        // Refresh tick coinciding with next yields a single hex load.
        src_v[1] = 32'hCAFE0042; src_h[1] = 1'b1;
        drive_src();
        n = 0;
        do begin
            tick();
            n++;
        end while ((cyc % RC) != RC - 1 && n < 2 * RC);
        check("refresh_align", 32'(cyc % RC), 32'(RC - 1));
        check("refresh_idle", 32'(busy), 32'd0);
        next = 1'b1; page_m = 1;
        ones = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            next = 1'b0;
            if (busy) ones++;
        end
        check("refresh_next_busy_cycles", 32'(ones), 32'd2);
        check("refresh_page", 32'(page), 32'd1);
        disp_m = expect_disp(src_v[1], src_h[1]);
        check_display("refresh");

        // Directed corner values, then random values and formats.
        tv = '{32'hFFFFFFFF, 32'd0, 32'd305, 32'h00000000, 32'd99999999};
        th = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 13; t++) begin
            tgt = (page_m + 1) % N_SRC;
            if (t < 5) begin
                v = tv[t];
                h = th[t];
            end else begin
                v = $urandom;
                if (t % 2 == 1) v = v >> $urandom_range(0, 31);
                h = 1'($urandom_range(0, 1));
            end
            src_v[tgt] = v; src_h[tgt] = h;
            drive_src();
            old_d = disp_m;
            new_d = expect_disp(v, h);
            lat   = h ? 3 : 35;
            pulse_next();
            for (int k = 2; k <= lat; k++) begin
                tick();
                if (k < lat) check_digit("trial_hold", old_d);
                else         check_digit("trial_new", new_d);
            end
            check("trial_page", 32'(page), 32'(tgt));
            disp_m = new_d;
            wait_idle(5);
            check_display("trial");
        end

        // Reset in the middle of a conversion.
        tgt = (page_m + 1) % N_SRC;
        src_v[tgt] = 32'd24681357; src_h[tgt] = 1'b0;
        drive_src();
        pulse_next();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check_reset_values("midreset");
        rst = 1'b0;
        page_m = 0;
        disp_m = expect_disp(src_v[0], src_h[0]);
        repeat (2) tick();
        wait_idle(60);
        check("midreset_page", 32'(page), 32'd0);
        check_display("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
